instr_fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the decode controller of the RV32I core.
//  - Owns the program counter and issues word fetches to instruction memory over a valid/ready request channel.
//  - Accepts in-order responses and buffers them with their PC in a small FIFO.
//  - Presents {inst, inst_pc} to decode with a valid/ready handshake.
//  - On a branch/jump redirect from execute: flushes buffered and in-flight fetches and restarts at the new PC.

---
 rtl/instr_fetch_unit_if.sv | 43 ++++
 rtl/instr_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: imem request/response, redirect and
// decode-side instruction handshake.
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC, credit-limited imem requests,
// in-flight tag queue and instruction buffer toward decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input logic                 clk,
  input logic                 rst_n,
  instr_fetch_unit_if.master  bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH = cnt_t'(FIFO_DEPTH);

  logic [31:0] pc_q, pc_d;
  cnt_t        out_q, out_d;
  cnt_t        drop_q, drop_d;
  cnt_t        cnt_q, cnt_d;
  logic [31:0] tag_q [FIFO_DEPTH];
  logic [31:0] tag_d [FIFO_DEPTH];
  ptr_t        tag_wp_q, tag_wp_d;
  ptr_t        tag_rp_q, tag_rp_d;
  logic [31:0] bpc_q [FIFO_DEPTH];
  logic [31:0] bpc_d [FIFO_DEPTH];
  logic [31:0] bins_q [FIFO_DEPTH];
  logic [31:0] bins_d [FIFO_DEPTH];
  ptr_t        bwp_q, bwp_d;
  ptr_t        brp_q, brp_d;

  logic        req_valid;
  logic        req_fire;
  logic        rsp;
  logic        redir;
  logic        push;
  logic        pop;
  logic        head_v;
  logic [CW:0] used;

  assign redir  = bus.redirect_valid;
  assign rsp    = bus.imem_rsp_valid;
  assign head_v = (cnt_q != '0);
  assign used   = {1'b0, out_q} + {1'b0, cnt_q};

  // Gated by rst_n so the request drops the instant reset asserts.
  assign req_valid = rst_n && !redir
                   && (used < {1'b0, DEPTH});
  assign req_fire  = req_valid && bus.imem_req_ready;

  always_comb begin
    pc_d     = pc_q;
    out_d    = out_q;
    drop_d   = drop_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    tag_wp_d = tag_wp_q;
    tag_rp_d = tag_rp_q;
    bpc_d    = bpc_q;
    bins_d   = bins_q;
    bwp_d    = bwp_q;
    brp_d    = brp_q;
    push     = 1'b0;
    pop      = 1'b0;

    if (req_fire) begin
      tag_d[tag_wp_q] = pc_q;
      tag_wp_d        = tag_wp_q + ptr_t'(1);
      pc_d            = pc_q + 32'd4;
    end
    if (rsp) begin
      tag_rp_d = tag_rp_q + ptr_t'(1);
    end
    out_d = out_q + cnt_t'(req_fire) - cnt_t'(rsp);

    if (redir) begin
      pc_d   = bus.redirect_pc & 32'hFFFF_FFFC;
      drop_d = out_q - cnt_t'(rsp);
      cnt_d  = '0;
      bwp_d  = '0;
      brp_d  = '0;
    end else begin
      push = rsp && (drop_q == '0);
      pop  = head_v && bus.inst_ready;
      if (rsp && (drop_q != '0)) begin
        drop_d = drop_q - cnt_t'(1);
      end
      if (push) begin
        bpc_d[bwp_q]  = tag_q[tag_rp_q];
        bins_d[bwp_q] = bus.imem_rsp_data;
        bwp_d         = bwp_q + ptr_t'(1);
      end
      if (pop) begin
        brp_d = brp_q + ptr_t'(1);
      end
      cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      tag_q    <= '{default: '0};
      tag_wp_q <= '0;
      tag_rp_q <= '0;
      bpc_q    <= '{default: '0};
      bins_q   <= '{default: '0};
      bwp_q    <= '0;
      brp_q    <= '0;
    end else begin
      assert (!(rsp && out_q == '0));
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      tag_wp_q <= tag_wp_d;
      tag_rp_q <= tag_rp_d;
      bpc_q    <= bpc_d;
      bins_q   <= bins_d;
      bwp_q    <= bwp_d;
      brp_q    <= brp_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = head_v;
  assign bus.inst    = head_v ? bins_q[brp_q] : NOP_INSTR;
  assign bus.inst_pc = head_v ? bpc_q[brp_q] : 32'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle-exact vector table plus
// randomised memory/decode/redirect run against a scoreboard.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk;
  logic rst_n;

  instr_fetch_unit_if ifc ();

  instr_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (2),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          irdy;
    bit          redir;
    logic [31:0] rpc;
    int          lat;
    bit          rv;
    logic [31:0] addr;
    bit          iv;
    logic [31:0] ipc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  vec_t        vecs[$];
  mem_t        mem_q[$];
  logic [31:0] exp_q[$];

  int n_cmp;
  int n_bad;
  int n_deliv;
  int cyc;
  int lat;

  bit          drv_irdy;
  bit          drv_qrdy;
  bit          drv_redir;
  logic [31:0] drv_rpc;

  bit          s_rv;
  logic [31:0] s_addr;
  bit          s_iv;
  logic [31:0] s_inst;
  logic [31:0] s_ipc;

  bit          prv_stall;
  logic [31:0] prv_addr;
  logic [31:0] next_req;

  function automatic logic [31:0] fdat(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void add(
    bit rst, bit irdy, bit redir, logic [31:0] rpc, int lt,
    bit rv, logic [31:0] addr, bit iv, logic [31:0] ipc);
    vec_t v;
    v = '{rst, irdy, redir, rpc, lt, rv, addr, iv, ipc};
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n                  = 1'b0;
    ifc.imem_req_ready     = 1'b0;
    ifc.imem_rsp_valid     = 1'b0;
    ifc.imem_rsp_data      = '0;
    ifc.redirect_valid     = 1'b0;
    ifc.redirect_pc        = '0;
    ifc.inst_ready         = 1'b0;
    #1;
    chk("rst_req_valid", 32'(ifc.imem_req_valid), 0);
    chk("rst_req_addr", ifc.imem_req_addr, RST_PC);
    chk("rst_inst_valid", 32'(ifc.inst_valid), 0);
    chk("rst_inst", ifc.inst, NOP);
    chk("rst_inst_pc", ifc.inst_pc, 0);
    mem_q.delete();
    exp_q.delete();
    prv_stall = 1'b0;
    next_req  = RST_PC;
  endtask

  task automatic cycle();
    logic [31:0] e;
    mem_t        m;
    @(negedge clk);
    rst_n              = 1'b1;
    ifc.redirect_valid = drv_redir;
    ifc.redirect_pc    = drv_rpc;
    ifc.inst_ready     = drv_irdy;
    ifc.imem_req_ready = drv_qrdy;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      ifc.imem_rsp_valid = 1'b1;
      ifc.imem_rsp_data  = fdat(mem_q[0].addr);
    end else begin
      ifc.imem_rsp_valid = 1'b0;
      ifc.imem_rsp_data  = $urandom;
    end
    #1;
    s_rv   = ifc.imem_req_valid;
    s_addr = ifc.imem_req_addr;
    s_iv   = ifc.inst_valid;
    s_inst = ifc.inst;
    s_ipc  = ifc.inst_pc;

    if (prv_stall && !drv_redir) begin
      chk("req_hold_valid", 32'(s_rv), 1);
      chk("req_hold_addr", s_addr, prv_addr);
    end
    prv_stall = s_rv && !drv_qrdy;
    prv_addr  = s_addr;
    if (drv_redir) chk("rv_in_redirect", 32'(s_rv), 0);
    if (!s_iv) begin
      chk("inst_nop", s_inst, NOP);
      chk("inst_pc_zero", s_ipc, 0);
    end

    if (ifc.imem_rsp_valid) void'(mem_q.pop_front());

    if (s_iv && drv_irdy && !drv_redir) begin
      n_deliv++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_inst: got pc %h, expected none",
                 s_ipc);
      end else begin
        e = exp_q.pop_front();
        chk("deliv_pc", s_ipc, e);
        chk("deliv_inst", s_inst, fdat(e));
      end
    end

    if (drv_redir) begin
      exp_q.delete();
      next_req = drv_rpc & 32'hFFFF_FFFC;
    end

    if (s_rv && drv_qrdy) begin
      chk("req_addr_seq", s_addr, next_req);
      m.addr = next_req;
      m.due  = cyc + lat;
      mem_q.push_back(m);
      exp_q.push_back(next_req);
      next_req = next_req + 32'd4;
    end
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    n_deliv = 0;
    cyc     = 0;
    lat     = 1;
    rst_n   = 1'b0;
    drv_irdy  = 1'b0;
    drv_qrdy  = 1'b1;
    drv_redir = 1'b0;
    drv_rpc   = '0;
    prv_stall = 1'b0;
    prv_addr  = '0;
    next_req  = RST_PC;
    ifc.imem_req_ready = 1'b0;
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = '0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    ifc.inst_ready     = 1'b0;

    // streaming from reset, 1-cycle memory
    add(1,1,0,0,1, 1,'h00,0,'h00);
    add(0,1,0,0,1, 1,'h04,0,'h00);
    add(0,1,0,0,1, 0,'h08,1,'h00);
    add(0,1,0,0,1, 1,'h08,1,'h04);
    add(0,1,0,0,1, 1,'h0c,0,'h00);
    add(0,1,0,0,1, 0,'h10,1,'h08);
    add(0,1,0,0,1, 1,'h10,1,'h0c);
    add(0,1,0,0,1, 1,'h14,0,'h00);
    add(0,1,0,0,1, 0,'h18,1,'h10);
    add(0,1,0,0,1, 1,'h18,1,'h14);
    // decode stalled 10 cycles, then drains
    add(1,0,0,0,1, 1,'h00,0,'h00);
    add(0,0,0,0,1, 1,'h04,0,'h00);
    for (int i = 0; i < 8; i++)
      add(0,0,0,0,1, 0,'h08,1,'h00);
    add(0,1,0,0,1, 0,'h08,1,'h00);
    add(0,1,0,0,1, 1,'h08,1,'h04);
    add(0,1,0,0,1, 1,'h0c,0,'h00);
    add(0,1,0,0,1, 0,'h10,1,'h08);
    // redirect with two requests in flight
    add(1,1,0,0,3, 1,'h00,0,'h00);
    add(0,1,0,0,3, 1,'h04,0,'h00);
    add(0,1,1,'h100,3, 0,'h08,0,'h00);
    add(0,1,0,0,3, 0,'h100,0,'h00);
    add(0,1,0,0,3, 1,'h100,0,'h00);
    add(0,1,0,0,3, 1,'h104,0,'h00);
    add(0,1,0,0,3, 0,'h108,0,'h00);
    add(0,1,0,0,3, 0,'h108,0,'h00);
    add(0,1,0,0,3, 0,'h108,1,'h100);
    add(0,1,0,0,3, 1,'h108,1,'h104);
    // redirect colliding with rsp and pop, unaligned target
    add(1,1,0,0,1, 1,'h00,0,'h00);
    add(0,1,0,0,1, 1,'h04,0,'h00);
    add(0,1,1,'h103,1, 0,'h08,1,'h00);
    add(0,1,0,0,1, 1,'h100,0,'h00);
    add(0,1,0,0,1, 1,'h104,0,'h00);
    add(0,1,0,0,1, 0,'h108,1,'h100);
    add(0,1,0,0,1, 1,'h108,1,'h104);
    // reset while the buffer holds two entries
    add(1,0,0,0,1, 1,'h00,0,'h00);
    add(0,0,0,0,1, 1,'h04,0,'h00);
    add(0,0,0,0,1, 0,'h08,1,'h00);
    add(0,0,0,0,1, 0,'h08,1,'h00);
    add(1,1,0,0,1, 1,'h00,0,'h00);
    add(0,1,0,0,1, 1,'h04,0,'h00);
    add(0,1,0,0,1, 0,'h08,1,'h00);

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      drv_irdy  = vecs[k].irdy;
      drv_qrdy  = 1'b1;
      drv_redir = vecs[k].redir;
      drv_rpc   = vecs[k].rpc;
      lat       = vecs[k].lat;
      cycle();
      chk($sformatf("v%0d_req_valid", k), 32'(s_rv),
          32'(vecs[k].rv));
      chk($sformatf("v%0d_req_addr", k), s_addr,
          vecs[k].addr);
      chk($sformatf("v%0d_inst_valid", k), 32'(s_iv),
          32'(vecs[k].iv));
      if (vecs[k].iv)
        chk($sformatf("v%0d_inst_pc", k), s_ipc,
            vecs[k].ipc);
    end

    // random ready/latency/redirect traffic
    do_reset();
    n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      drv_irdy  = ($urandom_range(0, 9) < 7);
      drv_qrdy  = 1'($urandom_range(0, 1));
      drv_redir = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0)
        drv_rpc = 32'hFFFF_FFF4;
      else
        drv_rpc = $urandom & 32'h0000_3FFF;
      lat = $urandom_range(1, 3);
      cycle();
    end
    chk("random_deliveries", 32'(n_deliv >= 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
